// File: rtl/bcd_updown_counter_n.sv
// N-digit BCD up/down counter with programmable terminal count, wrap/saturate
// limit handling, synchronous clear/load, full/empty flags and limit pulses.
module bcd_updown_counter_n #(
  parameter int unsigned DIGITS    = 2,
  parameter int unsigned MAX_COUNT = 99,
  parameter bit          WRAP      = 1'b0
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                clr,
  input  logic                load,
  input  logic [4*DIGITS-1:0] load_val,
  input  logic                en,
  input  logic                up,
  output logic [4*DIGITS-1:0] count,
  output logic                full,
  output logic                empty,
  output logic                ovf,
  output logic                udf,
  output logic                load_err
);

  localparam int unsigned W = 4 * DIGITS;

  function automatic logic [63:0] pow10(input int unsigned n);
    logic [63:0] r;
    r = 64'd1;
    for (int unsigned i = 0; i < n; i++) r = 64'(r * 64'd10);
    return r;
  endfunction

  function automatic logic [W-1:0] to_bcd(input int unsigned v);
    logic [W-1:0] r;
    int unsigned  x;
    r = '0;
    x = v;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x           = x / 10;
    end
    return r;
  endfunction

  localparam logic [63:0]  LIMIT   = pow10(DIGITS);
  localparam logic [W-1:0] MAX_BCD = to_bcd(MAX_COUNT);

  if (DIGITS < 1 || DIGITS > 8 || MAX_COUNT < 1 || 64'(MAX_COUNT) >= LIMIT) begin : g_param_err
    $error("bcd_updown_counter_n: illegal DIGITS/MAX_COUNT");
  end

  logic [W-1:0] count_q, count_d;
  logic [W-1:0] inc_c, dec_c;
  logic         carry_c, borrow_c, load_ok_c;
  logic         ovf_d, udf_d, load_err_d;

  // Single-cycle ripple increment: each digit sees the carry of all lower digits.
  always_comb begin
    inc_c   = count_q;
    carry_c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (carry_c) begin
        if (count_q[4*i +: 4] == 4'd9) begin
          inc_c[4*i +: 4] = 4'd0;
        end else begin
          inc_c[4*i +: 4] = 4'(count_q[4*i +: 4] + 4'd1);
          carry_c         = 1'b0;
        end
      end
    end
  end

  always_comb begin
    dec_c    = count_q;
    borrow_c = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow_c) begin
        if (count_q[4*i +: 4] == 4'd0) begin
          dec_c[4*i +: 4] = 4'd9;
        end else begin
          dec_c[4*i +: 4] = 4'(count_q[4*i +: 4] - 4'd1);
          borrow_c        = 1'b0;
        end
      end
    end
  end

  // With every digit valid, an unsigned compare of BCD vectors orders them decimally.
  always_comb begin
    load_ok_c = (load_val <= MAX_BCD);
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (load_val[4*i +: 4] > 4'd9) load_ok_c = 1'b0;
    end
  end

  always_comb begin
    count_d    = count_q;
    ovf_d      = 1'b0;
    udf_d      = 1'b0;
    load_err_d = 1'b0;
    if (clr) begin
      count_d = '0;
    end else if (load) begin
      if (load_ok_c) count_d    = load_val;
      else           load_err_d = 1'b1;
    end else if (en) begin
      if (up) begin
        if (count_q == MAX_BCD) begin
          ovf_d = 1'b1;
          if (WRAP) count_d = '0;
        end else begin
          count_d = inc_c;
        end
      end else begin
        if (count_q == '0) begin
          udf_d = 1'b1;
          if (WRAP) count_d = MAX_BCD;
        end else begin
          count_d = dec_c;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q  <= '0;
      ovf      <= 1'b0;
      udf      <= 1'b0;
      load_err <= 1'b0;
    end else begin
      count_q  <= count_d;
      ovf      <= ovf_d;
      udf      <= udf_d;
      load_err <= load_err_d;
    end
  end

  assign count = count_q;
  assign full  = (count_q == MAX_BCD);
  assign empty = (count_q == '0);

endmodule

// File: tb/tb_bcd_updown_counter_n.sv
// Directed bench: three counter configurations share one set of control inputs;
// each scenario checks only the instance it targets.
module tb_bcd_updown_counter_n;

  logic        clk, rst_n, clr, load, en, up;
  logic [11:0] load_val;

  logic [7:0]  a_count, b_count;
  logic [11:0] c_count;
  logic a_full, a_empty, a_ovf, a_udf, a_lerr;
  logic b_full, b_empty, b_ovf, b_udf, b_lerr;
  logic c_full, c_empty, c_ovf, c_udf, c_lerr;

  int n_chk  = 0;
  int n_pass = 0;

  bcd_updown_counter_n #(.DIGITS(2), .MAX_COUNT(99), .WRAP(1'b1)) u_a (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[7:0]),
    .en(en), .up(up), .count(a_count), .full(a_full), .empty(a_empty),
    .ovf(a_ovf), .udf(a_udf), .load_err(a_lerr));

  bcd_updown_counter_n #(.DIGITS(2), .MAX_COUNT(59), .WRAP(1'b0)) u_b (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val[7:0]),
    .en(en), .up(up), .count(b_count), .full(b_full), .empty(b_empty),
    .ovf(b_ovf), .udf(b_udf), .load_err(b_lerr));

  bcd_updown_counter_n #(.DIGITS(3), .MAX_COUNT(500), .WRAP(1'b1)) u_c (
    .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val),
    .en(en), .up(up), .count(c_count), .full(c_full), .empty(c_empty),
    .ovf(c_ovf), .udf(c_udf), .load_err(c_lerr));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [7:0] bcd2(input int v);
    logic [3:0] hi, lo;
    hi = 4'(v / 10);
    lo = 4'(v % 10);
    return {hi, lo};
  endfunction

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; en = 1'b0; up = 1'b1; load_val = '0;
    #12;
    check("rst_a_count", 32'(a_count), 32'h0);
    check("rst_a_flags", {a_full, a_empty, a_ovf, a_udf, a_lerr}, 32'b01000);
    check("rst_b_count", 32'(b_count), 32'h0);
    check("rst_b_flags", {b_full, b_empty, b_ovf, b_udf, b_lerr}, 32'b01000);
    check("rst_c_count", 32'(c_count), 32'h0);
    check("rst_c_flags", {c_full, c_empty, c_ovf, c_udf, c_lerr}, 32'b01000);

    // Count up 100 steps through the wrap on the 99 / wrap instance.
    rst_n = 1'b1; en = 1'b1; up = 1'b1;
    for (int k = 1; k <= 100; k++) begin
      step();
      check("a_up_count", 32'(a_count), 32'(bcd2(k % 100)));
      check("a_up_ovf",   32'(a_ovf),   32'(k == 100));
      check("a_up_full",  32'(a_full),  32'(k == 99));
    end

    // Saturation at 59.
    en = 1'b0; load = 1'b1; load_val = 12'h058;
    step(); check("b_load58", 32'(b_count), 32'h58);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step(); check("b_sat1_count", 32'(b_count), 32'h59); check("b_sat1_ovf", 32'(b_ovf), 32'h0);
    check("b_sat1_full", 32'(b_full), 32'h1);
    step(); check("b_sat2_count", 32'(b_count), 32'h59); check("b_sat2_ovf", 32'(b_ovf), 32'h1);
    step(); check("b_sat3_count", 32'(b_count), 32'h59); check("b_sat3_ovf", 32'(b_ovf), 32'h1);
    check("b_sat3_full", 32'(b_full), 32'h1);
    up = 1'b0;
    step(); check("b_down_count", 32'(b_count), 32'h58); check("b_down_ovf", 32'(b_ovf), 32'h0);

    // Three-digit borrow and underflow wrap to 500.
    en = 1'b0; load = 1'b1; load_val = 12'h100;
    step(); check("c_load100", 32'(c_count), 32'h100);
    load = 1'b0; en = 1'b1; up = 1'b0;
    step(); check("c_borrow", 32'(c_count), 32'h099);
    en = 1'b0; load = 1'b1; load_val = 12'h000;
    step(); check("c_load0", 32'(c_count), 32'h000); check("c_empty", 32'(c_empty), 32'h1);
    load = 1'b0; en = 1'b1; up = 1'b0;
    step(); check("c_wrap_count", 32'(c_count), 32'h500); check("c_wrap_udf", 32'(c_udf), 32'h1);
    check("c_wrap_full", 32'(c_full), 32'h1);
    en = 1'b0;
    step(); check("c_udf_clear", 32'(c_udf), 32'h0); check("c_hold", 32'(c_count), 32'h500);

    // Load rejection on the 59 instance.
    load = 1'b1; load_val = 12'h025;
    step(); check("b_load25", 32'(b_count), 32'h25); check("b_load25_err", 32'(b_lerr), 32'h0);
    load_val = 12'h03A;
    step(); check("b_bad_digit_count", 32'(b_count), 32'h25); check("b_bad_digit_err", 32'(b_lerr), 32'h1);
    load_val = 12'h060;
    step(); check("b_over_max_count", 32'(b_count), 32'h25); check("b_over_max_err", 32'(b_lerr), 32'h1);
    load_val = 12'h059;
    step(); check("b_load59", 32'(b_count), 32'h59); check("b_load59_err", 32'(b_lerr), 32'h0);
    load_val = 12'h042;
    step(); check("b_load42", 32'(b_count), 32'h42); check("b_load42_err", 32'(b_lerr), 32'h0);

    // Priority: clr beats load and en, then load beats en.
    clr = 1'b1; load = 1'b1; load_val = 12'h017; en = 1'b1; up = 1'b1;
    step(); check("prio_clr_count", 32'(b_count), 32'h00);
    check("prio_clr_pulses", {b_ovf, b_udf, b_lerr}, 32'h0);
    check("prio_clr_empty", 32'(b_empty), 32'h1);
    clr = 1'b0;
    step(); check("prio_load_count", 32'(b_count), 32'h17);
    clr = 1'b1; load_val = 12'h03A;
    step(); check("prio_clr_no_err", 32'(b_lerr), 32'h0);

    // Asynchronous reset while ovf is high on the 99 / wrap instance.
    clr = 1'b0; en = 1'b0; load = 1'b1; load_val = 12'h099;
    step(); check("a_load99", 32'(a_count), 32'h99);
    load = 1'b0; en = 1'b1; up = 1'b1;
    step(); check("a_ovf_pre_rst", 32'(a_ovf), 32'h1); check("a_wrap_pre_rst", 32'(a_count), 32'h00);
    load = 1'b1; load_val = 12'h050;
    step(); check("a_load50", 32'(a_count), 32'h50);
    load = 1'b0; load_val = 12'h099; load = 1'b1;
    step(); load = 1'b0;
    step(); check("a_ovf_again", 32'(a_ovf), 32'h1);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(a_count), 32'h0);
    check("async_rst_empty", 32'(a_empty), 32'h1);
    check("async_rst_ovf", 32'(a_ovf), 32'h0);
    #2 rst_n = 1'b1;
    step(); check("resume_count", 32'(a_count), 32'h01); check("resume_ovf", 32'(a_ovf), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/bcd_updown_counter_n.md
Name: bcd_updown_counter_n

Overview:
- Parametrised N-digit BCD up/down counter. It generalises the two-digit cascaded units/tens counter.
- Adds a configurable terminal value, a wrap or saturate mode, synchronous clear and load, full/empty flags, and overflow/underflow pulses.
- Used as the occupancy counter in the car-park FSM datapath. It feeds the 7-segment display path directly with BCD digits.

Parameters:
- DIGITS, 2, number of BCD digits. Legal range is 1..8.
- MAX_COUNT, 99, terminal count as a decimal integer. Legal range is 1..(10^DIGITS - 1). Converted to a BCD constant at elaboration.
- WRAP, 0, limit mode. 0 = saturate at the limits. 1 = wrap around (MAX_COUNT to 0 going up, 0 to MAX_COUNT going down).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- clr  in  1  synchronous clear to 0.
- load  in  1  synchronous load strobe.
- load_val  in  4*DIGITS  BCD value to load. Digit 0 is bits [3:0].
- en  in  1  count enable, one step per cycle.
- up  in  1  direction. 1 = increment, 0 = decrement.
- count  out  4*DIGITS  current value in BCD. Digit i is bits [4i+3:4i].
- full  out  1  high when count == MAX_COUNT.
- empty  out  1  high when count == 0.
- ovf  out  1  one-cycle overflow pulse.
- udf  out  1  one-cycle underflow pulse.
- load_err  out  1  one-cycle pulse when a load is rejected.

Behaviour:
- Reset (rst_n low, asynchronous):
  - count = 0, empty = 1, full = 0.
  - ovf, udf and load_err = 0.
  - Release is synchronous to clk. The first update is on the first rising edge with rst_n high.
- Per-edge priority: clr > load > en. Lower-priority inputs in the same cycle are ignored entirely; they raise no pulse.
- clr: count <- 0 on the next edge.
- load:
  - If every digit of load_val is <= 9 and the value is <= MAX_COUNT, count <- load_val.
  - Otherwise count is unchanged and load_err pulses.
- en with up=1:
  - If count < MAX_COUNT: increment in BCD. Digit i increments only when all lower digits are 9; a digit at 9 rolls to 0.
  - If count == MAX_COUNT: ovf pulses. WRAP=1 sets count <- 0; WRAP=0 holds count.
- en with up=0:
  - If count > 0: decrement in BCD. Digit i decrements only when all lower digits are 0; a digit at 0 rolls to 9.
  - If count == 0: udf pulses. WRAP=1 sets count <- MAX_COUNT; WRAP=0 holds count.
- Latency: one cycle. count changes on the edge that samples the request.
- Pulse timing:
  - ovf, udf and load_err are registered.
  - Each is high for exactly the one cycle after the triggering edge, aligned with the updated count.
  - They are cleared on the next edge unless re-triggered.
  - With en held at a limit in saturate mode, ovf or udf stays high for every cycle of the attempt.
- full and empty are combinational compares of the count register against constants. They are glitch-free with respect to inputs.
- Invariants:
  - Every digit of count is <= 9 at all times.
  - count is always <= MAX_COUNT.
  - All carry/borrow propagation completes within one cycle. There is no per-digit cascade delay.
- When MAX_COUNT < 10^DIGITS - 1, the step from MAX_COUNT never passes through values above MAX_COUNT.
- Illegal parameters (DIGITS outside 1..8, or MAX_COUNT out of range) cause an elaboration-time error.
- Reset asserted mid-count or mid-pulse clears everything immediately. No pulse survives reset.

Test Plan:
- DIGITS=2, MAX_COUNT=99, WRAP=1: reset, then en=1, up=1 for 100 cycles.
  - count steps 00 to 99, then 00.
  - ovf is high only in the cycle count shows 00.
  - full is high while count = 99.
- DIGITS=2, MAX_COUNT=59, WRAP=0: load 58, then up for 3 cycles.
  - count goes 59, 59, 59.
  - ovf is high on the 2nd and 3rd cycles; full = 1.
  - Then down for 1 cycle: count = 58, ovf = 0.
- DIGITS=3, MAX_COUNT=500, WRAP=1: load 100, then one down step.
  - count = 099, checking the borrow across two digits.
  - Then load 000 and step down: count = 500, udf pulses once.
- Load rejection, DIGITS=2, MAX_COUNT=59:
  - load_val = 0x3A (invalid digit): load_err pulses, count unchanged.
  - load_val = 0x60: load_err pulses, count unchanged.
  - load_val = 0x42: count = 42, no load_err.
- Priority: with count = 42, assert clr, load = 17 and en/up together.
  - count = 00, no pulses.
  - Next, assert load = 17 and en together: count = 17, not 18.
- Async reset mid-operation: assert rst_n low between clock edges during counting with ovf high.
  - count = 0, empty = 1, ovf = 0 immediately, without waiting for a clock edge.
  - After release, counting resumes from 00 on the first edge.
